// File: rtl/mesh_pkg.sv
// Shared definitions for the mesh endpoint: packet field map and width helpers.
// A packet is a flat vector; bit 0 is the valid flag and fields sit above it in order.
package mesh_pkg;

  localparam int MESH_CS = 3;
  localparam int MESH_PW = 8;
  localparam int MESH_PL = 1 + 4 * MESH_CS + MESH_PW;

  typedef enum logic [2:0] {
    FLD_VALID,
    FLD_DST_X,
    FLD_DST_Y,
    FLD_SRC_X,
    FLD_SRC_Y,
    FLD_PAYLOAD
  } mesh_field_e;

  // Lowest bit index of a packet field for a given coordinate width.
  function automatic int fld_lsb(input mesh_field_e f, input int cs);
    int lsb;
    case (f)
      FLD_VALID: lsb = 0;
      FLD_DST_X: lsb = 1;
      FLD_DST_Y: lsb = 1 + cs;
      FLD_SRC_X: lsb = 1 + 2 * cs;
      FLD_SRC_Y: lsb = 1 + 3 * cs;
      default:   lsb = 1 + 4 * cs;
    endcase
    return lsb;
  endfunction

  function automatic int payload_width(input int pl, input int cs);
    return pl - 1 - 4 * cs;
  endfunction

endpackage

// File: rtl/endpoint_fifo.sv
// Synchronous FIFO with first-word fall-through read. A push while full is
// accepted only when a pop happens in the same cycle.
module endpoint_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW + 1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // NOTE: the storage array has no reset; pointers and count alone define which
  // entries are live, so the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mesh_endpoint.sv
// Network interface between a core and its mesh router's local port: packetises
// and buffers outgoing traffic, checks and buffers incoming packets.
module mesh_endpoint
  import mesh_pkg::*;
#(
  parameter int PL       = MESH_PL,
  parameter int CS       = MESH_CS,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4,
  localparam int PW      = PL - 1 - 4 * CS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CS-1:0] node_X,
  input  logic [CS-1:0] node_Y,
  input  logic          tx_valid,
  output logic          tx_ready,
  input  logic [CS-1:0] tx_dst_X,
  input  logic [CS-1:0] tx_dst_Y,
  input  logic [PW-1:0] tx_payload,
  output logic [PL-1:0] pkt_out,
  input  logic          net_avail_in,
  input  logic [PL-1:0] pkt_in,
  output logic          net_avail_out,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic [CS-1:0] rx_src_X,
  output logic [CS-1:0] rx_src_Y,
  output logic [PW-1:0] rx_payload,
  output logic          err_misroute,
  output logic          err_overflow
);

  localparam int VLD_BIT = fld_lsb(FLD_VALID, CS);
  localparam int DX_LSB  = fld_lsb(FLD_DST_X, CS);
  localparam int DY_LSB  = fld_lsb(FLD_DST_Y, CS);
  localparam int SX_LSB  = fld_lsb(FLD_SRC_X, CS);
  localparam int SY_LSB  = fld_lsb(FLD_SRC_Y, CS);
  localparam int PAY_LSB = fld_lsb(FLD_PAYLOAD, CS);
  localparam int PWC     = payload_width(PL, CS);
  localparam int RXW     = 2 * CS + PWC;

  logic [PL-1:0]                 w_tx_pkt;
  logic [PL-1:0]                 w_tx_head;
  logic                          w_tx_full;
  logic                          w_tx_empty;
  logic                          w_tx_push;
  logic                          w_tx_pop;
  logic [$clog2(TX_DEPTH):0]     w_tx_count;
  logic [PL-1:0]                 r_pkt_out;

  logic                          w_in_valid;
  logic                          w_in_match;
  logic [RXW-1:0]                w_rx_wdata;
  logic [RXW-1:0]                w_rx_head;
  logic                          w_rx_full;
  logic                          w_rx_empty;
  logic                          w_rx_push;
  logic                          w_rx_pop;
  logic [$clog2(RX_DEPTH):0]     w_rx_count;
  logic                          r_err_misroute;
  logic                          r_err_overflow;
  logic                          w_unused_counts;

  // ---------------- TX path ----------------
  always_comb begin
    w_tx_pkt                   = '0;
    w_tx_pkt[VLD_BIT]          = 1'b1;
    w_tx_pkt[DX_LSB +: CS]     = tx_dst_X;
    w_tx_pkt[DY_LSB +: CS]     = tx_dst_Y;
    w_tx_pkt[SX_LSB +: CS]     = node_X;
    w_tx_pkt[SY_LSB +: CS]     = node_Y;
    w_tx_pkt[PAY_LSB +: PWC]   = tx_payload;
  end

  assign tx_ready  = ~w_tx_full;
  assign w_tx_push = tx_valid & ~w_tx_full;
  assign w_tx_pop  = ~w_tx_empty & net_avail_in;

  endpoint_fifo #(.WIDTH(PL), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_tx_push),
    .i_wdata (w_tx_pkt),
    .i_pop   (w_tx_pop),
    .o_rdata (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count)
  );

  // Every packet shows on pkt_out for exactly one cycle; idle cycles drive all zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pkt_out <= '0;
    else        r_pkt_out <= w_tx_pop ? w_tx_head : '0;
  end

  assign pkt_out = r_pkt_out;

  // ---------------- RX path ----------------
  assign w_in_valid = pkt_in[VLD_BIT];
  assign w_in_match = (pkt_in[DX_LSB +: CS] == node_X) && (pkt_in[DY_LSB +: CS] == node_Y);
  assign w_rx_wdata = {pkt_in[PAY_LSB +: PWC], pkt_in[SY_LSB +: CS], pkt_in[SX_LSB +: CS]};
  assign w_rx_pop   = rx_valid & rx_ready;
  assign w_rx_push  = w_in_valid & w_in_match & (~w_rx_full | w_rx_pop);

  endpoint_fifo #(.WIDTH(RXW), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_rx_push),
    .i_wdata (w_rx_wdata),
    .i_pop   (w_rx_pop),
    .o_rdata (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_count)
  );

  assign net_avail_out = ~w_rx_full;
  assign rx_valid      = ~w_rx_empty;

  // Head fields are masked while empty so stale RAM contents never reach the core.
  assign rx_src_X   = rx_valid ? w_rx_head[0 +: CS]      : '0;
  assign rx_src_Y   = rx_valid ? w_rx_head[CS +: CS]     : '0;
  assign rx_payload = rx_valid ? w_rx_head[2 * CS +: PWC] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_misroute <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      if (w_in_valid && !w_in_match)                           r_err_misroute <= 1'b1;
      if (w_in_valid && w_in_match && w_rx_full && !w_rx_pop)  r_err_overflow <= 1'b1;
    end
  end

  assign err_misroute = r_err_misroute;
  assign err_overflow = r_err_overflow;

  // Fill levels are exported by the FIFO but only full/empty matter here.
  assign w_unused_counts = ^{w_tx_count, w_rx_count};

endmodule

// File: tb/tb_mesh_endpoint.sv
// Self-checking bench for mesh_endpoint: directed scenarios plus a randomized run
// against a queue-based reference model.
`timescale 1ns/1ps
module tb_mesh_endpoint;

  localparam int CS  = 3;
  localparam int PW  = 8;
  localparam int PL  = 1 + 4 * CS + PW;
  localparam int TXD = 4;
  localparam int RXD = 4;
  localparam int RXW = 2 * CS + PW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CS-1:0] node_X, node_Y;
  logic          tx_valid, tx_ready;
  logic [CS-1:0] tx_dst_X, tx_dst_Y;
  logic [PW-1:0] tx_payload;
  logic [PL-1:0] pkt_out;
  logic          net_avail_in;
  logic [PL-1:0] pkt_in;
  logic          net_avail_out;
  logic          rx_valid, rx_ready;
  logic [CS-1:0] rx_src_X, rx_src_Y;
  logic [PW-1:0] rx_payload;
  logic          err_misroute, err_overflow;

  int n_checks = 0;
  int n_errors = 0;

  mesh_endpoint #(.PL(PL), .CS(CS), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .node_X        (node_X),
    .node_Y        (node_Y),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_dst_X      (tx_dst_X),
    .tx_dst_Y      (tx_dst_Y),
    .tx_payload    (tx_payload),
    .pkt_out       (pkt_out),
    .net_avail_in  (net_avail_in),
    .pkt_in        (pkt_in),
    .net_avail_out (net_avail_out),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_src_X      (rx_src_X),
    .rx_src_Y      (rx_src_Y),
    .rx_payload    (rx_payload),
    .err_misroute  (err_misroute),
    .err_overflow  (err_overflow)
  );

  always #5 clk = ~clk;

  // Packet image straight from the documented layout: bit 0 valid, then dst X/Y, src X/Y, payload.
  function automatic logic [PL-1:0] mk_pkt(input logic [CS-1:0] dx, input logic [CS-1:0] dy,
                                           input logic [CS-1:0] sx, input logic [CS-1:0] sy,
                                           input logic [PW-1:0] pl);
    return {pl, sy, sx, dy, dx, 1'b1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tx_valid     = 1'b0;
    tx_dst_X     = '0;
    tx_dst_Y     = '0;
    tx_payload   = '0;
    net_avail_in = 1'b0;
    pkt_in       = '0;
    rx_ready     = 1'b0;
  endtask

  task automatic do_reset(input logic [CS-1:0] nx, input logic [CS-1:0] ny);
    idle();
    node_X = nx;
    node_Y = ny;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send_rx(input logic [CS-1:0] dx, input logic [CS-1:0] dy,
                         input logic [CS-1:0] sx, input logic [CS-1:0] sy,
                         input logic [PW-1:0] pl);
    pkt_in = mk_pkt(dx, dy, sx, sy, pl);
    tick();
    pkt_in = '0;
  endtask

  task automatic test_reset();
    idle();
    node_X = 3'd1;
    node_Y = 3'd2;
    rst_n  = 1'b0;
    #3;
    n_checks++;
    if (pkt_out !== '0) begin
      n_errors++; $display("FAIL reset_pkt_out got %h expected 0", pkt_out);
    end
    n_checks++;
    if ({tx_ready, net_avail_out, rx_valid, err_misroute, err_overflow} !== 5'b11000) begin
      n_errors++;
      $display("FAIL reset_flags got %b expected 11000",
               {tx_ready, net_avail_out, rx_valid, err_misroute, err_overflow});
    end
    n_checks++;
    if ({rx_src_X, rx_src_Y, rx_payload} !== '0) begin
      n_errors++; $display("FAIL reset_rx_fields got %h expected 0", {rx_src_X, rx_src_Y, rx_payload});
    end
  endtask

  task automatic test_tx_single();
    logic [PL-1:0] exp;
    do_reset(3'd1, 3'd2);
    exp          = mk_pkt(3'd3, 3'd0, 3'd1, 3'd2, 8'hA5);
    net_avail_in = 1'b1;
    tx_valid     = 1'b1;
    tx_dst_X     = 3'd3;
    tx_dst_Y     = 3'd0;
    tx_payload   = 8'hA5;
    tick();
    tx_valid = 1'b0;
    n_checks++;
    if (pkt_out !== '0) begin
      n_errors++; $display("FAIL tx_single_accept_cycle got %h expected 0", pkt_out);
    end
    tick();
    n_checks++;
    if (pkt_out !== exp) begin
      n_errors++; $display("FAIL tx_single_pkt got %h expected %h", pkt_out, exp);
    end
    tick();
    n_checks++;
    if (pkt_out !== '0) begin
      n_errors++; $display("FAIL tx_single_one_cycle got %h expected 0", pkt_out);
    end
  endtask

  task automatic test_tx_backpressure();
    logic [PL-1:0] exp [TXD];
    do_reset(3'd1, 3'd2);
    net_avail_in = 1'b0;
    for (int i = 0; i < TXD; i++) begin
      tx_valid   = 1'b1;
      tx_dst_X   = CS'($urandom);
      tx_dst_Y   = CS'($urandom);
      tx_payload = PW'($urandom);
      exp[i]     = mk_pkt(tx_dst_X, tx_dst_Y, 3'd1, 3'd2, tx_payload);
      n_checks++;
      if (tx_ready !== 1'b1) begin
        n_errors++; $display("FAIL tx_fill_ready idx %0d got %b expected 1", i, tx_ready);
      end
      tick();
    end
    tx_valid = 1'b0;
    n_checks++;
    if (tx_ready !== 1'b0 || pkt_out !== '0) begin
      n_errors++;
      $display("FAIL tx_full_state got ready=%b pkt=%h expected ready=0 pkt=0", tx_ready, pkt_out);
    end
    net_avail_in = 1'b1;
    for (int i = 0; i < TXD; i++) begin
      tick();
      n_checks++;
      if (pkt_out !== exp[i]) begin
        n_errors++; $display("FAIL tx_drain idx %0d got %h expected %h", i, pkt_out, exp[i]);
      end
    end
    tick();
    n_checks++;
    if (pkt_out !== '0 || tx_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL tx_drained got ready=%b pkt=%h expected ready=1 pkt=0", tx_ready, pkt_out);
    end
    net_avail_in = 1'b0;
  endtask

  task automatic test_rx_single();
    do_reset(3'd2, 3'd2);
    send_rx(3'd2, 3'd2, 3'd0, 3'd1, 8'h3C);
    n_checks++;
    if ({rx_valid, rx_src_X, rx_src_Y, rx_payload} !== {1'b1, 3'd0, 3'd1, 8'h3C}) begin
      n_errors++;
      $display("FAIL rx_single_head got v=%b src=(%0d,%0d) pl=%h expected v=1 src=(0,1) pl=3c",
               rx_valid, rx_src_X, rx_src_Y, rx_payload);
    end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    n_checks++;
    if (rx_valid !== 1'b0 || rx_payload !== '0) begin
      n_errors++;
      $display("FAIL rx_single_pop got v=%b pl=%h expected v=0 pl=0", rx_valid, rx_payload);
    end
  endtask

  task automatic test_rx_overflow();
    logic [RXW-1:0] exp [RXD+1];
    logic [RXW-1:0] extra;
    do_reset(3'd2, 3'd2);
    for (int i = 0; i < RXD; i++) begin
      exp[i] = RXW'($urandom);
      send_rx(3'd2, 3'd2, exp[i][RXW-1 -: CS], exp[i][RXW-CS-1 -: CS], exp[i][PW-1:0]);
    end
    n_checks++;
    if (net_avail_out !== 1'b0) begin
      n_errors++; $display("FAIL rx_full_avail got %b expected 0", net_avail_out);
    end
    send_rx(3'd2, 3'd2, 3'd7, 3'd7, 8'hEE);
    n_checks++;
    if (err_overflow !== 1'b1) begin
      n_errors++; $display("FAIL rx_overflow_flag got %b expected 1", err_overflow);
    end
    rx_ready = 1'b1;
    for (int i = 0; i < RXD; i++) begin
      n_checks++;
      if ({rx_valid, rx_src_X, rx_src_Y, rx_payload} !== {1'b1, exp[i]}) begin
        n_errors++;
        $display("FAIL rx_overflow_intact idx %0d got %h expected %h", i,
                 {rx_valid, rx_src_X, rx_src_Y, rx_payload}, {1'b1, exp[i]});
      end
      tick();
    end
    rx_ready = 1'b0;
    n_checks++;
    if (rx_valid !== 1'b0) begin
      n_errors++; $display("FAIL rx_overflow_dropped got v=%b expected 0", rx_valid);
    end

    // Full FIFO with a pop and a push in the same cycle: both take effect, no error.
    do_reset(3'd2, 3'd2);
    for (int i = 0; i < RXD; i++) begin
      exp[i] = RXW'($urandom);
      send_rx(3'd2, 3'd2, exp[i][RXW-1 -: CS], exp[i][RXW-CS-1 -: CS], exp[i][PW-1:0]);
    end
    extra    = RXW'($urandom);
    rx_ready = 1'b1;
    send_rx(3'd2, 3'd2, extra[RXW-1 -: CS], extra[RXW-CS-1 -: CS], extra[PW-1:0]);
    rx_ready = 1'b0;
    exp[RXD] = extra;
    n_checks++;
    if (err_overflow !== 1'b0 || net_avail_out !== 1'b0) begin
      n_errors++;
      $display("FAIL rx_full_pop_push got ovf=%b avail=%b expected ovf=0 avail=0",
               err_overflow, net_avail_out);
    end
    rx_ready = 1'b1;
    for (int i = 1; i <= RXD; i++) begin
      n_checks++;
      if ({rx_valid, rx_src_X, rx_src_Y, rx_payload} !== {1'b1, exp[i]}) begin
        n_errors++;
        $display("FAIL rx_pop_push_order idx %0d got %h expected %h", i,
                 {rx_valid, rx_src_X, rx_src_Y, rx_payload}, {1'b1, exp[i]});
      end
      tick();
    end
    rx_ready = 1'b0;
  endtask

  task automatic test_misroute();
    do_reset(3'd2, 3'd2);
    send_rx(3'd2, 3'd2, 3'd5, 3'd6, 8'h11);
    send_rx(3'd1, 3'd1, 3'd3, 3'd3, 8'h22);
    n_checks++;
    if ({err_misroute, err_overflow} !== 2'b10) begin
      n_errors++;
      $display("FAIL misroute_flags got mis=%b ovf=%b expected mis=1 ovf=0", err_misroute, err_overflow);
    end
    n_checks++;
    if ({rx_valid, rx_src_X, rx_src_Y, rx_payload} !== {1'b1, 3'd5, 3'd6, 8'h11}) begin
      n_errors++;
      $display("FAIL misroute_head got %h expected %h",
               {rx_valid, rx_src_X, rx_src_Y, rx_payload}, {1'b1, 3'd5, 3'd6, 8'h11});
    end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    pkt_in    = mk_pkt(3'd2, 3'd2, 3'd4, 3'd4, 8'h33);
    pkt_in[0] = 1'b0;
    tick();
    pkt_in = '0;
    n_checks++;
    if (rx_valid !== 1'b0 || err_misroute !== 1'b1) begin
      n_errors++;
      $display("FAIL misroute_not_buffered got v=%b mis=%b expected v=0 mis=1", rx_valid, err_misroute);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset(3'd2, 3'd2);
    net_avail_in = 1'b0;
    rx_ready     = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tx_valid   = 1'b1;
      tx_dst_X   = CS'(i);
      tx_payload = PW'($urandom);
      send_rx(3'd2, 3'd2, CS'(i), 3'd0, PW'($urandom));
    end
    tx_valid = 1'b0;
    send_rx(3'd0, 3'd3, 3'd1, 3'd1, 8'h44);
    n_checks++;
    if ({rx_valid, err_misroute, tx_ready, net_avail_out} !== 4'b1111) begin
      n_errors++;
      $display("FAIL midflight_setup got %b expected 1111", {rx_valid, err_misroute, tx_ready, net_avail_out});
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pkt_out, tx_ready, net_avail_out, rx_valid, rx_src_X, rx_src_Y, rx_payload,
         err_misroute, err_overflow} !== {{PL{1'b0}}, 3'b110, {RXW{1'b0}}, 2'b00}) begin
      n_errors++;
      $display("FAIL midflight_reset_outputs got pkt=%h rdy=%b avail=%b v=%b rx=%h mis=%b ovf=%b",
               pkt_out, tx_ready, net_avail_out, rx_valid, {rx_src_X, rx_src_Y, rx_payload},
               err_misroute, err_overflow);
    end
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    net_avail_in = 1'b1;
    tick();
    tick();
    n_checks++;
    if (pkt_out !== '0 || rx_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL midflight_discarded got pkt=%h v=%b expected pkt=0 v=0", pkt_out, rx_valid);
    end
    net_avail_in = 1'b0;
  endtask

  task automatic test_random(input int ncyc);
    logic [PL-1:0]  txq[$];
    logic [RXW-1:0] rxq[$];
    logic [PL-1:0]  exp_pkt;
    logic [RXW-1:0] exp_head;
    logic           exp_mis, exp_ovf, tx_pop, rx_pop, rx_full, v;
    logic [CS-1:0]  dx, dy, sx, sy;
    logic [PW-1:0]  pl;
    do_reset(3'd2, 3'd2);
    exp_mis = 1'b0;
    exp_ovf = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      tx_valid     = ($urandom_range(0, 2) != 0);
      tx_dst_X     = CS'($urandom);
      tx_dst_Y     = CS'($urandom);
      tx_payload   = PW'($urandom);
      net_avail_in = ($urandom_range(0, 3) != 0);
      rx_ready     = ($urandom_range(0, 2) == 0);
      v  = ($urandom_range(0, 3) != 0);
      dx = ($urandom_range(0, 7) != 0) ? 3'd2 : CS'($urandom);
      dy = ($urandom_range(0, 7) != 0) ? 3'd2 : CS'($urandom);
      sx = CS'($urandom);
      sy = CS'($urandom);
      pl = PW'($urandom);
      pkt_in    = mk_pkt(dx, dy, sx, sy, pl);
      pkt_in[0] = v;

      tx_pop  = (txq.size() > 0) && net_avail_in;
      exp_pkt = tx_pop ? txq[0] : '0;
      if (tx_pop) void'(txq.pop_front());
      if (tx_valid && (txq.size() + (tx_pop ? 1 : 0)) < TXD)
        txq.push_back(mk_pkt(tx_dst_X, tx_dst_Y, 3'd2, 3'd2, tx_payload));

      rx_pop  = (rxq.size() > 0) && rx_ready;
      rx_full = (rxq.size() == RXD);
      if (rx_pop) void'(rxq.pop_front());
      if (v) begin
        if (dx == 3'd2 && dy == 3'd2) begin
          if (!rx_full || rx_pop) rxq.push_back({sx, sy, pl});
          else                    exp_ovf = 1'b1;
        end else begin
          exp_mis = 1'b1;
        end
      end
      exp_head = (rxq.size() > 0) ? rxq[0] : '0;

      tick();
      n_checks++;
      if (pkt_out !== exp_pkt) begin
        n_errors++; $display("FAIL rand_pkt_out cyc %0d got %h expected %h", c, pkt_out, exp_pkt);
      end
      n_checks++;
      if (tx_ready !== (txq.size() < TXD)) begin
        n_errors++; $display("FAIL rand_tx_ready cyc %0d got %b expected %b", c, tx_ready, txq.size() < TXD);
      end
      n_checks++;
      if ({net_avail_out, rx_valid} !== {rxq.size() < RXD, rxq.size() > 0}) begin
        n_errors++;
        $display("FAIL rand_rx_status cyc %0d got avail=%b v=%b expected avail=%b v=%b",
                 c, net_avail_out, rx_valid, rxq.size() < RXD, rxq.size() > 0);
      end
      n_checks++;
      if ({rx_src_X, rx_src_Y, rx_payload} !== exp_head) begin
        n_errors++;
        $display("FAIL rand_rx_head cyc %0d got %h expected %h", c, {rx_src_X, rx_src_Y, rx_payload}, exp_head);
      end
      n_checks++;
      if ({err_misroute, err_overflow} !== {exp_mis, exp_ovf}) begin
        n_errors++;
        $display("FAIL rand_err cyc %0d got mis=%b ovf=%b expected mis=%b ovf=%b",
                 c, err_misroute, err_overflow, exp_mis, exp_ovf);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_tx_backpressure();
    test_rx_single();
    test_rx_overflow();
    test_misroute();
    test_reset_midflight();
    test_random(3000);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
